// File: rtl/tlb_op_sequencer.sv
// TLB operation sequencer: runs TLBP/TLBR/TLBWI/TLBWR against a synchronous
// TLB array from the MEM stage, stalls the pipeline meanwhile, and hands the
// results plus a one-cycle commit strobe to CP0.
module tlb_op_sequencer #(
  parameter int unsigned TLB_LINE_NUM    = 32,
  parameter int unsigned PROBE_PER_CYCLE = 8,
  parameter int unsigned IDX_W           = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 op_req,
  input  logic                       flush_exception,
  input  logic [31:0]                cp0_index,
  input  logic [31:0]                cp0_random,
  output logic                       stall,
  output logic [IDX_W-1:0]           probe_grp,
  input  logic [PROBE_PER_CYCLE-1:0] probe_match,
  output logic [IDX_W-1:0]           rd_idx,
  input  logic [31:0]                rd_entry_hi,
  input  logic [31:0]                rd_page_mask,
  input  logic [31:0]                rd_entry_lo0,
  input  logic [31:0]                rd_entry_lo1,
  output logic                       tlb_we,
  output logic [IDX_W-1:0]           tlb_widx,
  output logic [3:0]                 tlb_commit,
  output logic [31:0]                index_out,
  output logic [31:0]                entry_hi_out,
  output logic [31:0]                page_mask_out,
  output logic [31:0]                entry_lo0_out,
  output logic [31:0]                entry_lo1_out
);

  localparam logic [IDX_W-1:0] GRP_STEP = IDX_W'(PROBE_PER_CYCLE);
  localparam logic [IDX_W-1:0] LAST_GRP = IDX_W'(TLB_LINE_NUM - PROBE_PER_CYCLE);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_P_CHECK = 3'd1;
  localparam logic [2:0] S_P_ISSUE = 3'd2;
  localparam logic [2:0] S_R_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [IDX_W-1:0] grp_q, grp_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [31:0]      index_q, index_d;
  logic [31:0]      ehi_q, ehi_d;
  logic [31:0]      pm_q, pm_d;
  logic [31:0]      lo0_q, lo0_d;
  logic [31:0]      lo1_q, lo1_d;

  logic [3:0]       op_sel;
  logic             busy;
  logic             start;
  logic             abort;
  logic             hit;
  logic [IDX_W-1:0] hit_pos;

  // Only the low IDX_W bits of Index/Random address the array.
  logic unused_bits;
  assign unused_bits = ^{cp0_index[31:IDX_W], cp0_random[31:IDX_W]};

  // Fixed-priority pick of one op: tlbp > tlbr > tlbwi > tlbwr.
  always_comb begin
    op_sel = 4'b0000;
    if (op_req[0])      op_sel = 4'b0001;
    else if (op_req[1]) op_sel = 4'b0010;
    else if (op_req[2]) op_sel = 4'b0100;
    else if (op_req[3]) op_sel = 4'b1000;
  end

  assign busy  = (state_q == S_P_CHECK) || (state_q == S_P_ISSUE) ||
                 (state_q == S_R_WAIT)  || (state_q == S_WRITE);
  assign start = (state_q == S_IDLE) && (op_req != 4'b0000) && !flush_exception;
  assign abort = busy && flush_exception;

  // Lowest matching entry within the current probe group.
  always_comb begin
    hit     = 1'b0;
    hit_pos = '0;
    for (int i = 0; i < int'(PROBE_PER_CYCLE); i++) begin
      if (probe_match[i] && !hit) begin
        hit     = 1'b1;
        hit_pos = IDX_W'(i);
      end
    end
  end

  // Next-state and result-capture logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    grp_d    = grp_q;
    rd_idx_d = rd_idx_q;
    widx_d   = widx_q;
    index_d  = index_q;
    ehi_d    = ehi_q;
    pm_d     = pm_q;
    lo0_d    = lo0_q;
    lo1_d    = lo1_q;
    if (abort) begin
      // Flushed op leaves results untouched and never commits.
      state_d = S_IDLE;
      grp_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d = op_sel;
            if (op_sel[0]) begin
              grp_d   = '0;
              state_d = S_P_CHECK;
            end else if (op_sel[1]) begin
              rd_idx_d = cp0_index[IDX_W-1:0];
              state_d  = S_R_WAIT;
            end else begin
              widx_d  = op_sel[2] ? cp0_index[IDX_W-1:0] : cp0_random[IDX_W-1:0];
              state_d = S_WRITE;
            end
          end
        end
        S_P_CHECK: begin
          // probe_grp advances while leaving P_CHECK so the array sees the
          // next group during P_ISSUE and answers in the following P_CHECK.
          if (hit) begin
            index_d = 32'(grp_q + hit_pos);
            grp_d   = '0;
            state_d = S_DONE;
          end else if (grp_q == LAST_GRP) begin
            index_d = 32'h8000_0000 | 32'(cp0_index[IDX_W-1:0]);
            grp_d   = '0;
            state_d = S_DONE;
          end else begin
            grp_d   = grp_q + GRP_STEP;
            state_d = S_P_ISSUE;
          end
        end
        S_P_ISSUE: state_d = S_P_CHECK;
        S_R_WAIT: begin
          ehi_d   = rd_entry_hi;
          pm_d    = rd_page_mask;
          lo0_d   = rd_entry_lo0;
          lo1_d   = rd_entry_lo1;
          state_d = S_DONE;
        end
        S_WRITE: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 4'b0000;
      grp_q    <= '0;
      rd_idx_q <= '0;
      widx_q   <= '0;
      index_q  <= '0;
      ehi_q    <= '0;
      pm_q     <= '0;
      lo0_q    <= '0;
      lo1_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      grp_q    <= grp_d;
      rd_idx_q <= rd_idx_d;
      widx_q   <= widx_d;
      index_q  <= index_d;
      ehi_q    <= ehi_d;
      pm_q     <= pm_d;
      lo0_q    <= lo0_d;
      lo1_q    <= lo1_d;
    end
  end

  // Read index goes out in the request cycle so data is back in R_WAIT.
  assign rd_idx = (start && op_sel[1]) ? cp0_index[IDX_W-1:0] : rd_idx_q;

  assign stall         = start || busy;
  assign probe_grp     = grp_q;
  assign tlb_we        = (state_q == S_WRITE) && !flush_exception && !rst;
  assign tlb_widx      = widx_q;
  assign tlb_commit    = ((state_q == S_DONE) && !rst) ? op_q : 4'b0000;
  assign index_out     = index_q;
  assign entry_hi_out  = ehi_q;
  assign page_mask_out = pm_q;
  assign entry_lo0_out = lo0_q;
  assign entry_lo1_out = lo1_q;

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Scoreboard bench for tlb_op_sequencer: driver pushes expectations from a
// rule-level model, a negedge monitor pops and compares.
module tb_tlb_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op_req;
  logic        flush_exception;
  logic [31:0] cp0_index, cp0_random;
  logic        stall;
  logic [4:0]  probe_grp, rd_idx, tlb_widx;
  logic [7:0]  probe_match;
  logic [31:0] rd_entry_hi, rd_page_mask, rd_entry_lo0, rd_entry_lo1;
  logic        tlb_we;
  logic [3:0]  tlb_commit;
  logic [31:0] index_out, entry_hi_out, page_mask_out, entry_lo0_out, entry_lo1_out;

  tlb_op_sequencer dut (
    .clk(clk), .rst(rst), .op_req(op_req), .flush_exception(flush_exception),
    .cp0_index(cp0_index), .cp0_random(cp0_random), .stall(stall),
    .probe_grp(probe_grp), .probe_match(probe_match), .rd_idx(rd_idx),
    .rd_entry_hi(rd_entry_hi), .rd_page_mask(rd_page_mask),
    .rd_entry_lo0(rd_entry_lo0), .rd_entry_lo1(rd_entry_lo1),
    .tlb_we(tlb_we), .tlb_widx(tlb_widx), .tlb_commit(tlb_commit),
    .index_out(index_out), .entry_hi_out(entry_hi_out), .page_mask_out(page_mask_out),
    .entry_lo0_out(entry_lo0_out), .entry_lo1_out(entry_lo1_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  commit;
    logic [31:0] idx, ehi, pm, lo0, lo1;
  } commit_t;
  typedef struct {
    int         cyc;
    logic [4:0] idx;
  } we_t;

  commit_t cq[$];
  we_t     wq[$];
  int      sq[$];
  int      n_tests = 0;
  int      n_fail  = 0;
  int      cyc     = 0;

  // Array contents seen by the sequencer.
  logic [31:0] match_vec;
  logic [31:0] ehi_arr[32], pm_arr[32], lo0_arr[32], lo1_arr[32];
  // Held CP0 result values as the model expects them.
  logic [31:0] m_idx, m_ehi, m_pm, m_lo0, m_lo1;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous TLB array: one-cycle probe and read latency.
  always @(posedge clk) begin
    probe_match  <= 8'(match_vec >> probe_grp);
    rd_entry_hi  <= ehi_arr[rd_idx];
    rd_page_mask <= pm_arr[rd_idx];
    rd_entry_lo0 <= lo0_arr[rd_idx];
    rd_entry_lo1 <= lo1_arr[rd_idx];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: stall every cycle, write and commit events when they appear.
  always @(negedge clk) begin
    if (sq.size() > 0) begin
      int e;
      e = sq.pop_front();
      if (e >= 0) chk("stall", 32'(stall), 32'(e));
    end
    if (wq.size() > 0 && wq[0].cyc < cyc) begin
      void'(wq.pop_front());
      chk("we_missing", 32'(tlb_we), 32'd1);
    end
    if (tlb_we !== 1'b0) begin
      if (wq.size() == 0) chk("we_unexpected", 32'(tlb_we), 32'd0);
      else begin
        we_t w;
        w = wq.pop_front();
        chk("we_cycle", 32'(cyc), 32'(w.cyc));
        chk("we_idx", 32'(tlb_widx), 32'(w.idx));
      end
    end
    if (cq.size() > 0 && cq[0].cyc < cyc) begin
      void'(cq.pop_front());
      chk("commit_missing", 32'(tlb_commit), 32'hf);
    end
    if (tlb_commit !== 4'b0000) begin
      if (cq.size() == 0) chk("commit_unexpected", 32'(tlb_commit), 32'd0);
      else begin
        commit_t c;
        c = cq.pop_front();
        chk("commit_cycle", 32'(cyc), 32'(c.cyc));
        chk("commit_op", 32'(tlb_commit), 32'(c.commit));
        chk("index_out", index_out, c.idx);
        chk("entry_hi_out", entry_hi_out, c.ehi);
        chk("page_mask_out", page_mask_out, c.pm);
        chk("entry_lo0_out", entry_lo0_out, c.lo0);
        chk("entry_lo1_out", entry_lo1_out, c.lo1);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      op_req = 4'b0000;
      flush_exception = 1'($urandom_range(0, 1));
      cp0_random = $urandom;
      sq.push_back(0);
    end
  endtask

  // Issue one op; flush_at is the cycle (request=0) carrying a flush, -1 none.
  task automatic run_op(input logic [3:0] op, input logic [31:0] idx, input logic [31:0] rnd,
                        input logic [31:0] mv, input int flush_at);
    int lat, t0, last;
    bit aborted, found;
    logic [31:0] pidx;
    commit_t c;
    we_t w;
    lat = 2;
    found = 0;
    pidx = 32'h8000_0000 | (idx & 32'h1f);
    if (op[0]) begin
      for (int i = 0; i < 32; i++)
        if (mv[i] && !found) begin
          found = 1;
          pidx = 32'(i);
          lat = 2 * (i / 8) + 2;
        end
      if (!found) lat = 8;
    end
    aborted = (flush_at >= 0) && (flush_at < lat);

    @(posedge clk); #1;
    t0 = cyc;
    op_req = op;
    cp0_index = idx;
    cp0_random = rnd;
    match_vec = mv;
    flush_exception = (flush_at == 0);
    sq.push_back((aborted && flush_at == 0) ? 0 : 1);
    if (!aborted) begin
      if (op[0]) m_idx = pidx;
      else if (op[1]) begin
        m_ehi = ehi_arr[idx[4:0]];
        m_pm  = pm_arr[idx[4:0]];
        m_lo0 = lo0_arr[idx[4:0]];
        m_lo1 = lo1_arr[idx[4:0]];
      end else begin
        w.cyc = t0 + 1;
        w.idx = op[2] ? idx[4:0] : rnd[4:0];
        wq.push_back(w);
      end
      c.cyc = t0 + lat;
      c.commit = op[0] ? 4'b0001 : op[1] ? 4'b0010 : op[2] ? 4'b0100 : 4'b1000;
      c.idx = m_idx; c.ehi = m_ehi; c.pm = m_pm; c.lo0 = m_lo0; c.lo1 = m_lo1;
      cq.push_back(c);
    end
    last = aborted ? flush_at : lat;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      cp0_random = $urandom;
      flush_exception = (k == flush_at);
      sq.push_back((k < lat) ? 1 : 0);
    end
    if (aborted) begin
      @(posedge clk); #1;
      op_req = 4'b0000;
      flush_exception = 1'b0;
      sq.push_back(0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_we"}, 32'(tlb_we), 32'd0);
    chk({tag, "_commit"}, 32'(tlb_commit), 32'd0);
    chk({tag, "_probe_grp"}, 32'(probe_grp), 32'd0);
    chk({tag, "_rd_idx"}, 32'(rd_idx), 32'd0);
    chk({tag, "_tlb_widx"}, 32'(tlb_widx), 32'd0);
    chk({tag, "_index_out"}, index_out, 32'd0);
    chk({tag, "_entry_hi_out"}, entry_hi_out, 32'd0);
    chk({tag, "_outs"}, page_mask_out | entry_lo0_out | entry_lo1_out, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    op_req = 4'b0000;
    flush_exception = 1'b0;
    cp0_index = '0;
    cp0_random = '0;
    match_vec = '0;
    m_idx = '0; m_ehi = '0; m_pm = '0; m_lo0 = '0; m_lo1 = '0;
    for (int i = 0; i < 32; i++) begin
      ehi_arr[i] = $urandom; pm_arr[i] = $urandom;
      lo0_arr[i] = $urandom; lo1_arr[i] = $urandom;
    end
    ehi_arr[3] = 32'h1234_5020;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      sq.push_back(-1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sq.push_back(0);
    @(negedge clk);
    check_all_zero("reset");

    // Directed cases.
    run_op(4'b0001, 32'd0, 32'd0, 32'h0004_0000, -1);      // hit entry 18 in group 16
    idle(1);
    run_op(4'b0001, 32'd7, 32'd0, 32'h0, -1);              // full miss
    idle(1);
    run_op(4'b0010, 32'd3, 32'd0, 32'h0, -1);              // tlbr index 3
    idle(1);
    run_op(4'b1000, 32'd0, 32'd29, 32'h0, -1);             // tlbwr random 29
    idle(1);
    run_op(4'b0100, 32'd11, 32'd0, 32'h0, 1);              // tlbwi flushed in WRITE
    idle(1);
    run_op(4'b0100, 32'd5, 32'd0, 32'h0, -1);              // back-to-back tlbwi
    run_op(4'b0001, 32'd9, 32'd0, 32'h0000_0001, -1);      // then tlbp hit entry 0
    run_op(4'b0001, 32'd1, 32'd0, 32'h0000_1200, -1);      // multi-hit, lowest wins
    run_op(4'b0010, 32'd20, 32'd0, 32'h0, 2);              // flush in DONE still commits
    run_op(4'b1000, 32'd0, 32'd4, 32'h0, 0);               // flush in IDLE: no start
    run_op(4'b1110, 32'd17, 32'd6, 32'h0, -1);             // priority picks tlbr
    run_op(4'b1111, 32'd2, 32'd6, 32'h8000_0000, -1);      // priority picks tlbp
    idle(2);

    // Reset during cycle 3 of a probe.
    @(posedge clk); #1;
    op_req = 4'b0001; match_vec = '0; cp0_index = 32'd1; flush_exception = 1'b0;
    sq.push_back(1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 3) rst = 1'b1;
      sq.push_back(1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    op_req = 4'b0000;
    sq.push_back(0);
    m_idx = '0; m_ehi = '0; m_pm = '0; m_lo0 = '0; m_lo1 = '0;
    @(negedge clk);
    check_all_zero("midop_reset");

    // Randomized ops.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] mv;
      int fa;
      case ($urandom_range(0, 3))
        0: mv = '0;
        1: mv = 32'd1 << $urandom_range(0, 31);
        default: mv = $urandom & $urandom & $urandom;
      endcase
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
      run_op(4'($urandom_range(1, 15)), $urandom, $urandom, mv, fa);
      idle(int'($urandom_range(0, 2)));
    end

    idle(4);
    chk("commit_queue_drained", 32'(cq.size()), 32'd0);
    chk("we_queue_drained", 32'(wq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
